// File: rtl/spi_reg_ctrl_pkg.sv
// Shared definitions for the SPI register-access controller: FSM states,
// command word bit positions and configuration word layout.
package spi_reg_ctrl_pkg;

    typedef enum logic [2:0] {
        S_CFG,
        S_IDLE,
        S_CMD,
        S_RDWAIT,
        S_DATA
    } state_t;

    // Command bit positions counted down from the word MSB (bit W-1 is rw)
    localparam int CMD_RW_BIT    = 1;
    localparam int CMD_BURST_BIT = 2;

    // cpol/cpha sit directly above the width field in config_data
    localparam int CFG_CPOL_OFS  = 1;
    localparam int CFG_CPHA_OFS  = 0;

endpackage

// File: rtl/spi_reg_ctrl_timeout.sv
// Frame watchdog: counts enabled cycles since the last clear and flags the
// terminal count so the controller can abandon a stalled frame.
module spi_reg_ctrl_timeout
    import spi_reg_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = en && (cnt == TC_VAL);

endmodule

// File: rtl/spi_slave_reg_ctrl.sv
// Turns SPI word frames into register-bank reads and writes.
// Optional build macro: SPI_REG_CTRL_BURST_EN (auto-incrementing burst frames).
module spi_slave_reg_ctrl
    import spi_reg_ctrl_pkg::*;
#(
    parameter int SPI_MAX_WIDTH_LOG = 4,
    parameter int REG_ADDR_W        = 4,
    parameter int TIMEOUT_CYC       = 1024,
    parameter bit DEFAULT_CPOL      = 1'b0,
    parameter bit DEFAULT_CPHA      = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           spi_start,
    input  logic                           spi_finish,
    input  logic [2**SPI_MAX_WIDTH_LOG-1:0] dout,
    output logic [2**SPI_MAX_WIDTH_LOG-1:0] din,
    output logic                           config_req,
    output logic [SPI_MAX_WIDTH_LOG+1:0]   config_data,
    input  logic                           cfg_update,
    input  logic                           cfg_cpol,
    input  logic                           cfg_cpha,
    output logic [REG_ADDR_W-1:0]          reg_addr,
    output logic                           reg_wr_en,
    output logic [2**SPI_MAX_WIDTH_LOG-1:0] reg_wdata,
    output logic                           reg_rd_en,
    input  logic [2**SPI_MAX_WIDTH_LOG-1:0] reg_rdata,
    output logic                           busy,
    output logic                           err,
    output logic                           err_sticky,
    input  logic                           err_clr
);

    localparam int W = 2**SPI_MAX_WIDTH_LOG;
    localparam logic [SPI_MAX_WIDTH_LOG+1:0] CFG_RST =
        {DEFAULT_CPOL, DEFAULT_CPHA, {SPI_MAX_WIDTH_LOG{1'b1}}};
`ifdef SPI_REG_CTRL_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    state_t                state, state_nxt;
    logic [REG_ADDR_W-1:0] addr_q, addr_nxt;
    logic [W-1:0]          din_q;
    logic                  rw_q, burst_q, cfg_pending;
    logic                  to_clr, to_en, to_tc;
    logic                  abort, wr_go, rd_go, cmd_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CFG;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        // burst writes advance the address once the strobe has gone out
        addr_nxt  = (reg_wr_en && burst_q) ? addr_q + 1'b1 : addr_q;
        rd_go     = 1'b0;
        wr_go     = 1'b0;
        abort     = 1'b0;
        cmd_done  = 1'b0;
        case (state)
            S_CFG: state_nxt = S_IDLE;
            S_IDLE: begin
                if (cfg_pending) begin
                    state_nxt = S_CFG;
                end else if (spi_start) begin
                    state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                if (spi_finish) begin
                    cmd_done = 1'b1;
                    addr_nxt = dout[REG_ADDR_W-1:0];
                    if (dout[W-CMD_RW_BIT]) begin
                        state_nxt = S_DATA;
                    end else begin
                        rd_go     = 1'b1;
                        state_nxt = S_RDWAIT;
                    end
                end else if (to_tc) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_RDWAIT: state_nxt = S_DATA;
            S_DATA: begin
                if (spi_finish) begin
                    wr_go = rw_q;
                    if (!burst_q) begin
                        state_nxt = S_IDLE;
                    end else if (!rw_q) begin
                        addr_nxt  = addr_q + 1'b1;
                        rd_go     = 1'b1;
                        state_nxt = S_RDWAIT;
                    end
                end else if (to_tc) begin
                    // a burst frame has no length, so its timeout is the normal end
                    abort     = !burst_q;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_CFG;
        endcase
    end

    assign to_en  = (state == S_CMD) || (state == S_RDWAIT) || (state == S_DATA);
    assign to_clr = spi_start || spi_finish ||
                    ((state_nxt != state) && ((state_nxt == S_CMD) || (state_nxt == S_DATA)));

    spi_reg_ctrl_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (to_clr),
        .en   (to_en),
        .tc   (to_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            din_q       <= '0;
            rw_q        <= 1'b0;
            burst_q     <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wdata   <= '0;
            config_req  <= 1'b0;
            config_data <= CFG_RST;
            cfg_pending <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            addr_q     <= addr_nxt;
            reg_wr_en  <= wr_go;
            config_req <= (state == S_CFG);
            busy       <= (state_nxt != S_IDLE);
            err        <= abort;
            if (wr_go) begin
                reg_wdata <= dout;
            end
            if (abort) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
            if (cmd_done) begin
                rw_q    <= dout[W-CMD_RW_BIT];
                burst_q <= BURST_EN && dout[W-CMD_BURST_BIT];
                if (dout[W-CMD_RW_BIT]) begin
                    din_q <= dout;
                end
            end
            if (state == S_RDWAIT) begin
                din_q <= reg_rdata;
            end
            if (cfg_update) begin
                config_data[SPI_MAX_WIDTH_LOG+CFG_CPOL_OFS] <= cfg_cpol;
                config_data[SPI_MAX_WIDTH_LOG+CFG_CPHA_OFS] <= cfg_cpha;
                cfg_pending <= 1'b1;
            end else if (state == S_CFG) begin
                cfg_pending <= 1'b0;
            end
        end
    end

    // the read address must be valid in the same cycle as the read strobe
    assign reg_addr  = rd_go ? addr_nxt : addr_q;
    assign reg_rd_en = rd_go;
    assign din       = (state == S_IDLE) ? {{(W-1){1'b0}}, err_sticky} : din_q;

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Directed plus randomized bench for spi_slave_reg_ctrl with a register-bank
// model and expected results derived from the frame-level behaviour.
module tb_spi_slave_reg_ctrl;

    localparam int WL = 4;
    localparam int W  = 16;
    localparam int AW = 4;
    localparam int TO = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          spi_start = 1'b0;
    logic          spi_finish = 1'b0;
    logic [W-1:0]  dout = '0;
    logic [W-1:0]  din;
    logic          config_req;
    logic [WL+1:0] config_data;
    logic          cfg_update = 1'b0;
    logic          cfg_cpol = 1'b0;
    logic          cfg_cpha = 1'b0;
    logic [AW-1:0] reg_addr;
    logic          reg_wr_en;
    logic [W-1:0]  reg_wdata;
    logic          reg_rd_en;
    logic [W-1:0]  reg_rdata = '0;
    logic          busy;
    logic          err;
    logic          err_sticky;
    logic          err_clr = 1'b0;

    bit [W-1:0]    mem [16];
    bit [W-1:0]    mdl [16];
    logic [19:0]   wr_log [$];
    logic [3:0]    rd_log [$];
    int            cfg_cnt = 0;
    int            err_cnt = 0;
    int            checks = 0;
    int            passed = 0;

    spi_slave_reg_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_start  (spi_start),
        .spi_finish (spi_finish),
        .dout       (dout),
        .din        (din),
        .config_req (config_req),
        .config_data(config_data),
        .cfg_update (cfg_update),
        .cfg_cpol   (cfg_cpol),
        .cfg_cpha   (cfg_cpha),
        .reg_addr   (reg_addr),
        .reg_wr_en  (reg_wr_en),
        .reg_wdata  (reg_wdata),
        .reg_rd_en  (reg_rd_en),
        .reg_rdata  (reg_rdata),
        .busy       (busy),
        .err        (err),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    // register bank: read data valid one cycle after the strobe
    always @(posedge clk) begin
        if (reg_rd_en) reg_rdata <= mem[reg_addr];
        if (reg_wr_en) mem[reg_addr] <= reg_wdata;
    end

    always @(negedge clk) begin
        if (reg_wr_en) wr_log.push_back({reg_addr, reg_wdata});
        if (reg_rd_en) rd_log.push_back(reg_addr);
        if (config_req) cfg_cnt++;
        if (err) err_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", passed, checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic spi_word(input logic [W-1:0] w);
        spi_start = 1'b1;
        cyc(1);
        spi_start = 1'b0;
        cyc(3);
        dout = w;
        spi_finish = 1'b1;
        cyc(1);
        spi_finish = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [W-1:0] d, input logic [9:0] junk);
        logic [W-1:0] cmd;
        cmd = {1'b1, 1'b0, junk, a};
        spi_word(cmd);
        chk("wr_echo", din, cmd);
        chk("wr_busy", busy, 1);
        cyc(1);
        spi_word(d);
        cyc(2);
        chk("wr_count", wr_log.size(), 1);
        if (wr_log.size() != 0) chk("wr_entry", wr_log.pop_front(), {a, d});
        chk("wr_busy_end", busy, 0);
        mdl[a] = d;
    endtask

    task automatic do_read(input logic [3:0] a, input logic [9:0] junk);
        logic [W-1:0] cmd;
        cmd = {1'b0, 1'b0, junk, a};
        spi_word(cmd);
        cyc(2);
        chk("rd_din", din, mdl[a]);
        spi_word(W'($urandom));
        cyc(2);
        chk("rd_count", rd_log.size(), 1);
        if (rd_log.size() != 0) chk("rd_addr", rd_log.pop_front(), a);
        chk("rd_no_write", wr_log.size(), 0);
        chk("rd_busy_end", busy, 0);
    endtask

    task automatic wait_err(output int lat);
        lat = -1;
        for (int i = 1; i <= 1200; i++) begin
            cyc(1);
            if (err) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int c0;
        int e0;
        int lat;

        cyc(3);
        chk("rst_config_req", config_req, 0);
        chk("rst_config_data", config_data, 6'h0F);
        chk("rst_busy", busy, 0);
        chk("rst_err", {err, err_sticky}, 0);
        chk("rst_strobes", {reg_wr_en, reg_rd_en}, 0);
        chk("rst_din", din, 0);
        rst_n = 1'b1;
        cyc(1);
        chk("cfg_req_pulse", config_req, 1);
        cyc(1);
        chk("cfg_req_single", config_req, 0);
        chk("cfg_req_count", cfg_cnt, 1);
        chk("idle_busy", busy, 0);

        do_write(4'h3, 16'h1234, 10'h000);
        do_write(4'h5, 16'hBEEF, 10'h2A5);
        do_read(4'h5, 10'h000);
        do_read(4'h3, 10'h3FF);

        // abandoned frame: command only
        e0 = err_cnt;
        spi_word(16'h8003);
        wait_err(lat);
        chk("to_latency", lat, TO);
        chk("to_sticky", err_sticky, 1);
        chk("to_busy", busy, 0);
        chk("to_idle_din", din, 16'h0001);
        cyc(1);
        chk("to_err_pulse", err_cnt - e0, 1);
        chk("to_no_write", wr_log.size(), 0);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("to_clr_sticky", err_sticky, 0);
        chk("to_clr_din", din, 0);

        // reconfiguration request during an active frame
        c0 = cfg_cnt;
        spi_word(16'h8007);
        cfg_cpol = 1'b1;
        cfg_cpha = 1'b1;
        cfg_update = 1'b1;
        cyc(1);
        cfg_update = 1'b0;
        chk("cfg_latched", config_data, 6'h3F);
        cyc(5);
        chk("cfg_deferred", cfg_cnt - c0, 0);
        chk("cfg_frame_busy", busy, 1);
        spi_word(16'h5A5A);
        cyc(4);
        chk("cfg_applied", cfg_cnt - c0, 1);
        chk("cfg_data_after", config_data, 6'h3F);
        chk("cfg_frame_write", wr_log.size(), 1);
        if (wr_log.size() != 0) chk("cfg_frame_entry", wr_log.pop_front(), {4'h7, 16'h5A5A});
        mdl[7] = 16'h5A5A;
        chk("cfg_busy_end", busy, 0);

        // pending reconfiguration wins over a start in the same idle cycle
        c0 = cfg_cnt;
        cfg_cpol = 1'b0;
        cfg_cpha = 1'b1;
        cfg_update = 1'b1;
        cyc(1);
        cfg_update = 1'b0;
        spi_start = 1'b1;
        cyc(1);
        spi_start = 1'b0;
        dout = 16'h8001;
        spi_finish = 1'b1;
        cyc(1);
        spi_finish = 1'b0;
        cyc(3);
        chk("prio_start_ignored", busy, 0);
        chk("prio_cfg_once", cfg_cnt - c0, 1);
        chk("prio_cfg_data", config_data, 6'h1F);

        // reset in the middle of a command word
        spi_start = 1'b1;
        cyc(1);
        spi_start = 1'b0;
        cyc(1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cfg", config_data, 6'h0F);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_req", config_req, 0);
        c0 = cfg_cnt;
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        chk("mid_rst_reconfig", cfg_cnt - c0, 1);
        chk("mid_rst_idle", busy, 0);

        for (int k = 0; k < 16; k++) begin
            logic [3:0] a;
            a = 4'($urandom_range(15, 0));
            if ($urandom_range(1, 0) == 1) do_write(a, W'($urandom), 10'($urandom));
            else do_read(a, 10'($urandom));
        end

`ifdef SPI_REG_CTRL_BURST_EN
        spi_word(16'hC00F);
        cyc(1);
        spi_word(16'h1111);
        cyc(2);
        spi_word(16'h2222);
        cyc(2);
        spi_word(16'h3333);
        cyc(2);
        chk("burst_count", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            chk("burst_w0", wr_log.pop_front(), {4'hF, 16'h1111});
            chk("burst_w1", wr_log.pop_front(), {4'h0, 16'h2222});
            chk("burst_w2", wr_log.pop_front(), {4'h1, 16'h3333});
        end
        e0 = err_cnt;
        lat = -1;
        for (int i = 1; i <= 1200; i++) begin
            cyc(1);
            if (!busy) begin
                lat = i;
                break;
            end
        end
        chk("burst_end_idle", busy, 0);
        chk("burst_end_no_err", err_cnt - e0, 0);
        chk("burst_end_sticky", err_sticky, 0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
